// File: rtl/htp_fetch_fifo.sv
// Paper-tape reader fetch engine: request/ready handshake, even-parity check, FWFT frame FIFO.
// Build option HTP_PERR_DROP_EN discards frames that fail parity instead of queueing them.
module htp_fetch_fifo #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset,
  output logic          tp_dreq,
  input  logic          tp_drdy,
  input  logic [7:0]    tp_din,
  input  logic          enable,
  input  logic          cpu_rd,
  output logic          cpu_valid,
  output logic [7:0]    cpu_data,
  output logic          cpu_perr,
  output logic [AW:0]   count,
  output logic [7:0]    perr_cnt,
  output logic          timeout,
  input  logic          stat_clr
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int CW = AW + 1;
  localparam logic [AW:0]   FULL_LVL = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t          state_reg;
  logic            dreq_reg;
  logic            timeout_reg;
  logic [7:0]      perr_cnt_reg;
  logic [TW-1:0]   tmo_reg;

  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;

  logic            frame_perr;
  logic            capture;
  logic            tmo_hit;
  logic            push;
  logic            pop;
  logic            not_empty;
  logic [8:0]      head;

  assign frame_perr = ^tp_din;
  assign capture    = (state_reg == S_WAIT) && tp_drdy;
  assign tmo_hit    = (state_reg == S_WAIT) && !tp_drdy && (tmo_reg == TMO_MAX);
  assign not_empty  = (count_reg != '0);
  assign pop        = cpu_rd && not_empty;

`ifdef HTP_PERR_DROP_EN
  assign push = capture && !frame_perr;
`else
  assign push = capture;
`endif

  // Handshake FSM plus the sticky status it owns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      dreq_reg     <= 1'b0;
      tmo_reg      <= '0;
      timeout_reg  <= 1'b0;
      perr_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (enable && (count_reg != FULL_LVL)) begin
            dreq_reg  <= 1'b1;
            tmo_reg   <= '0;
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tp_drdy || tmo_hit) begin
            dreq_reg  <= 1'b0;
            state_reg <= S_DROP;
          end else begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end
        S_DROP: begin
          // Reader must release ready before the next request edge.
          if (!tp_drdy) state_reg <= S_IDLE;
        end
        default: begin
          dreq_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase

      if (stat_clr) begin
        timeout_reg  <= 1'b0;
        perr_cnt_reg <= '0;
      end else begin
        if (tmo_hit) timeout_reg <= 1'b1;
        if (capture && frame_perr && (perr_cnt_reg != 8'hFF))
          perr_cnt_reg <= perr_cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {frame_perr, tp_din};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is read combinationally so the CPU sees the oldest frame without a read cycle.
  assign head      = mem[rd_ptr_reg];
  assign cpu_valid = not_empty;
  assign cpu_data  = not_empty ? head[7:0] : 8'h00;
`ifdef HTP_PERR_DROP_EN
  assign cpu_perr  = 1'b0;
`else
  assign cpu_perr  = not_empty & head[8];
`endif

  assign tp_dreq  = dreq_reg;
  assign count    = count_reg;
  assign perr_cnt = perr_cnt_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_htp_fetch_fifo.sv
// Directed bench for htp_fetch_fifo with a behavioural tape-reader model.
module tb_htp_fetch_fifo;

  logic       clk = 1'b0;
  logic       reset, tp_drdy, enable, cpu_rd, stat_clr;
  logic [7:0] tp_din;
  logic       tp_dreq, cpu_valid, cpu_perr, timeout;
  logic [7:0] cpu_data, perr_cnt;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] frame_q[$];
  bit         reader_on = 1'b1;

  always #5 clk = ~clk;

  htp_fetch_fifo #(.DEPTH(8), .AW(3), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .tp_dreq(tp_dreq), .tp_drdy(tp_drdy), .tp_din(tp_din),
    .enable(enable), .cpu_rd(cpu_rd), .cpu_valid(cpu_valid), .cpu_data(cpu_data),
    .cpu_perr(cpu_perr), .count(count), .perr_cnt(perr_cnt), .timeout(timeout),
    .stat_clr(stat_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Reader: ready rises on the 9th cycle of request, drops one cycle after request falls.
  initial begin
    int   dcnt = 0;
    logic prev = 1'b0;
    tp_drdy = 1'b0;
    tp_din  = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (tp_dreq) begin
        dcnt++;
        if (dcnt == 9 && reader_on) begin
          tp_din  = (frame_q.size() != 0) ? frame_q.pop_front() : 8'h5A;
          tp_drdy = 1'b1;
        end
      end else begin
        dcnt = 0;
        if (!prev) tp_drdy = 1'b0;
      end
      prev = tp_dreq;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_dreq(input logic lvl, input int limit, input string tag);
    int i = 0;
    while (tp_dreq !== lvl && i < limit) begin tick(); i++; end
    check(tag, tp_dreq, lvl);
  endtask

  task automatic fetch_one(input logic [7:0] frame);
    frame_q.push_back(frame);
    enable = 1'b1;
    wait_dreq(1'b1, 10, "fetch_req");
    enable = 1'b0;
    tick(14);
  endtask

  task automatic pop_check(input logic [7:0] exp, input logic exp_perr, input string tag);
    check({tag, "_valid"}, cpu_valid, 1'b1);
    check({tag, "_data"}, cpu_data, exp);
    check({tag, "_perr"}, cpu_perr, exp_perr);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
  endtask

  initial begin
    int         i;
    int         hi;
    int         rises;
    logic       prev;
    logic [7:0] drain [8];
    logic [7:0] exp_byte;

    reset = 1'b1; enable = 1'b0; cpu_rd = 1'b0; stat_clr = 1'b0;
    tick(3);
    check("rst_dreq", tp_dreq, 1'b0);
    check("rst_valid", cpu_valid, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_perr_cnt", perr_cnt, 8'd0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_data", cpu_data, 8'h00);
    reset = 1'b0;
    tick();

    // Good frame
    frame_q.push_back(8'hC3);
    enable = 1'b1;
    wait_dreq(1'b1, 5, "t1_req");
    enable = 1'b0;
    i = 0;
    while (!cpu_valid && i < 12) begin tick(); i++; end
    check("t1_count", count, 4'd1);
    pop_check(8'hC3, 1'b0, "t1_head");
    check("t1_empty", cpu_valid, 1'b0);

    // Bad-parity frame
    fetch_one(8'h43);
    check("t2_perr_cnt", perr_cnt, 8'd1);
`ifdef HTP_PERR_DROP_EN
    check("t2_dropped", cpu_valid, 1'b0);
`else
    pop_check(8'h43, 1'b1, "t2_head");
`endif

    // Fill to capacity, then one pop lets exactly one more fetch through
    for (int k = 0; k < 8; k++) frame_q.push_back(8'(k));
    enable = 1'b1;
    i = 0;
    while (count != 4'd8 && i < 300) begin tick(); i++; end
    check("t3_full", count, 4'd8);
    hi = 0;
    for (int k = 0; k < 30; k++) begin tick(); if (tp_dreq) hi++; end
    check("t3_dreq_held", hi, 0);
    check("t3_perr_cnt", perr_cnt, 8'd5);
    pop_check(8'h00, 1'b0, "t3_pop0");
    rises = 0;
    prev  = tp_dreq;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (tp_dreq && !prev) rises++;
      prev = tp_dreq;
    end
    check("t3_one_refetch", rises, 1);
    check("t3_refull", count, 4'd8);
    enable = 1'b0;
`ifdef HTP_PERR_DROP_EN
    drain = '{8'h03, 8'h05, 8'h06, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
`else
    drain = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h5A};
`endif
    for (int k = 0; k < 8; k++) begin
      exp_byte = drain[k];
`ifdef HTP_PERR_DROP_EN
      pop_check(exp_byte, 1'b0, "t3_drain");
`else
      pop_check(exp_byte, ^exp_byte, "t3_drain");
`endif
    end
    check("t3_drained", count, 4'd0);

    // Reader never answers
    reader_on = 1'b0;
    enable = 1'b1;
    wait_dreq(1'b1, 5, "t4_req");
    hi = 0;
    while (tp_dreq && hi < 40) begin hi++; tick(); end
    check("t4_dreq_width", hi, 16);
    check("t4_timeout", timeout, 1'b1);
    wait_dreq(1'b1, 6, "t4_rerequest");
    enable = 1'b0;
    tick(20);
    reader_on = 1'b1;
    check("t4_idle", tp_dreq, 1'b0);
    check("t4_no_push", count, 4'd0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("t4_clr_timeout", timeout, 1'b0);
    check("t4_clr_perr_cnt", perr_cnt, 8'd0);

    // Simultaneous push and pop at count=3
    fetch_one(8'h11);
    fetch_one(8'h22);
    fetch_one(8'h33);
    check("t5_count3", count, 4'd3);
    frame_q.push_back(8'h44);
    enable = 1'b1;
    wait_dreq(1'b1, 5, "t5_req");
    enable = 1'b0;
    tick(8);
    check("t5_head", cpu_data, 8'h11);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    check("t5_count_same", count, 4'd3);
    tick(4);
    pop_check(8'h22, 1'b0, "t5_pop1");
    pop_check(8'h33, 1'b0, "t5_pop2");
    pop_check(8'h44, 1'b0, "t5_pop3");
    check("t5_empty", count, 4'd0);

    // Reset during an outstanding request
    fetch_one(8'h01);
    check("t6_perr_cnt", perr_cnt, 8'd1);
`ifdef HTP_PERR_DROP_EN
    check("t6_pre_count", count, 4'd0);
`else
    check("t6_pre_count", count, 4'd1);
`endif
    enable = 1'b1;
    wait_dreq(1'b1, 5, "t6_req");
    tick(3);
    reset = 1'b1;
    tick();
    check("t6_dreq", tp_dreq, 1'b0);
    check("t6_count", count, 4'd0);
    check("t6_valid", cpu_valid, 1'b0);
    check("t6_perr_cnt0", perr_cnt, 8'd0);
    enable = 1'b0;
    reset  = 1'b0;
    tick(20);
    check("t6_rest", tp_dreq, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
